// File: rtl/axi_error_capture.sv
// AXI4-Lite error reporter: sticky maskable error bits, first-error snapshot with timestamp,
// coherent 64-bit packet/error-event counters and a level interrupt.
module axi_error_capture #(
  parameter int         ERR_WIDTH  = 32,
  parameter int         DATA_WORDS = 16,
  parameter logic [7:0] ADDR_MASK  = 8'hFF
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     eth_active,
  input  logic [ERR_WIDTH-1:0]     error_in,
  input  logic [DATA_WORDS*32-1:0] error_data,
  input  logic                     pkt_strobe,
  output logic                     irq,
  output logic                     run_status,
  input  logic [31:0]              S_AXI_AWADDR,
  input  logic [2:0]               S_AXI_AWPROT,
  input  logic                     S_AXI_AWVALID,
  output logic                     S_AXI_AWREADY,
  input  logic [31:0]              S_AXI_WDATA,
  input  logic [3:0]               S_AXI_WSTRB,
  input  logic                     S_AXI_WVALID,
  output logic                     S_AXI_WREADY,
  output logic [1:0]               S_AXI_BRESP,
  output logic                     S_AXI_BVALID,
  input  logic                     S_AXI_BREADY,
  input  logic [31:0]              S_AXI_ARADDR,
  input  logic [2:0]               S_AXI_ARPROT,
  input  logic                     S_AXI_ARVALID,
  output logic                     S_AXI_ARREADY,
  output logic [31:0]              S_AXI_RDATA,
  output logic [1:0]               S_AXI_RRESP,
  output logic                     S_AXI_RVALID,
  input  logic                     S_AXI_RREADY
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int         DW_IDX      = (DATA_WORDS > 1) ? $clog2(DATA_WORDS) : 1;

  localparam logic [5:0] IDX_RUN_STATUS = 6'd0;
  localparam logic [5:0] IDX_CONTROL    = 6'd1;
  localparam logic [5:0] IDX_ERROR      = 6'd2;
  localparam logic [5:0] IDX_MASK       = 6'd3;
  localparam logic [5:0] IDX_FIRST_ERR  = 6'd4;
  localparam logic [5:0] IDX_PKTS_H     = 6'd5;
  localparam logic [5:0] IDX_PKTS_L     = 6'd6;
  localparam logic [5:0] IDX_EVENTS_H   = 6'd7;
  localparam logic [5:0] IDX_EVENTS_L   = 6'd8;
  localparam logic [5:0] IDX_TS_H       = 6'd9;
  localparam logic [5:0] IDX_TS_L       = 6'd10;
  localparam logic [5:0] IDX_DATA_BASE  = 6'd16;

  function automatic logic [5:0] reg_index(input logic [31:0] addr);
    return addr[7:2] & ADDR_MASK[7:2];
  endfunction

  function automatic logic [31:0] zext_err(input logic [ERR_WIDTH-1:0] v);
    logic [31:0] r;
    r = '0;
    r[ERR_WIDTH-1:0] = v;
    return r;
  endfunction

  // AXI channel state
  logic        ready_en_reg;
  logic        aw_held_reg;
  logic        w_held_reg;
  logic [5:0]  aw_idx_reg;
  logic [31:0] wdata_reg;
  logic        bvalid_reg;
  logic [1:0]  bresp_reg;
  logic        rvalid_reg;
  logic [31:0] rdata_reg;
  logic [1:0]  rresp_reg;

  // Control and status state
  logic                 capture_en_reg;
  logic                 irq_en_reg;
  logic [ERR_WIDTH-1:0] error_reg;
  logic [ERR_WIDTH-1:0] mask_reg;
  logic [ERR_WIDTH-1:0] first_err_reg;
  logic                 run_status_reg;
  logic                 irq_reg;
  logic [63:0]          cycle_cnt_reg;
  logic [63:0]          pkts_reg;
  logic [63:0]          err_events_reg;
  logic [63:0]          first_ts_reg;
  logic [31:0]          pkts_shadow_reg;
  logic [31:0]          events_shadow_reg;
  logic [31:0]          ts_shadow_reg;
  logic                 pkts_shadow_valid_reg;
  logic                 events_shadow_valid_reg;
  logic                 ts_shadow_valid_reg;
  logic [31:0]          err_data_reg [DATA_WORDS];
  logic [31:0]          snap_word [DATA_WORDS];

  logic                 aw_hs;
  logic                 w_hs;
  logic                 ar_hs;
  logic                 do_write;
  logic                 wr_okay;
  logic [5:0]           rd_idx;
  logic [DW_IDX-1:0]    rd_off;
  logic [31:0]          rd_data;
  logic [1:0]           rd_resp;
  logic [ERR_WIDTH-1:0] w1c;
  logic [ERR_WIDTH-1:0] error_masked_in;
  logic                 clr_counters;
  logic                 armed;
  logic                 take_snapshot;

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_WSTRB,
                           S_AXI_AWADDR[31:8], S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[31:8], S_AXI_ARADDR[1:0]};

  assign S_AXI_AWREADY = ready_en_reg & ~aw_held_reg & ~bvalid_reg;
  assign S_AXI_WREADY  = ready_en_reg & ~w_held_reg & ~bvalid_reg;
  assign S_AXI_ARREADY = ready_en_reg & ~rvalid_reg;
  assign S_AXI_BVALID  = bvalid_reg;
  assign S_AXI_BRESP   = bresp_reg;
  assign S_AXI_RVALID  = rvalid_reg;
  assign S_AXI_RDATA   = rdata_reg;
  assign S_AXI_RRESP   = rresp_reg;
  assign irq           = irq_reg;
  assign run_status    = run_status_reg;

  assign aw_hs    = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs     = S_AXI_WVALID & S_AXI_WREADY;
  assign ar_hs    = S_AXI_ARVALID & S_AXI_ARREADY;
  assign do_write = aw_held_reg & w_held_reg;
  assign wr_okay  = (aw_idx_reg == IDX_CONTROL) || (aw_idx_reg == IDX_ERROR) ||
                    (aw_idx_reg == IDX_MASK);
  assign rd_idx   = reg_index(S_AXI_ARADDR);
  assign rd_off   = DW_IDX'(rd_idx - IDX_DATA_BASE);

  assign w1c             = (do_write && aw_idx_reg == IDX_ERROR) ? wdata_reg[ERR_WIDTH-1:0] : '0;
  assign clr_counters    = do_write && (aw_idx_reg == IDX_CONTROL) && wdata_reg[2];
  assign error_masked_in = capture_en_reg ? (error_in & ~mask_reg) : '0;
  assign armed           = ((error_reg & ~mask_reg) == '0);
  assign take_snapshot   = armed && (error_masked_in != '0);

  // Snapshot words stored most-significant first so register 16 holds the top word
  for (genvar gi = 0; gi < DATA_WORDS; gi++) begin : g_snap_word
    assign snap_word[gi] = error_data[(DATA_WORDS-1-gi)*32 +: 32];
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      ready_en_reg <= 1'b0;
      aw_held_reg  <= 1'b0;
      w_held_reg   <= 1'b0;
      aw_idx_reg   <= '0;
      wdata_reg    <= '0;
      bvalid_reg   <= 1'b0;
      bresp_reg    <= RESP_OKAY;
    end else begin
      ready_en_reg <= 1'b1;
      if (aw_hs) begin
        aw_held_reg <= 1'b1;
        aw_idx_reg  <= reg_index(S_AXI_AWADDR);
      end
      if (w_hs) begin
        w_held_reg <= 1'b1;
        wdata_reg  <= S_AXI_WDATA;
      end
      if (do_write) begin
        aw_held_reg <= 1'b0;
        w_held_reg  <= 1'b0;
        bvalid_reg  <= 1'b1;
        bresp_reg   <= wr_okay ? RESP_OKAY : RESP_DECERR;
      end else if (bvalid_reg && S_AXI_BREADY) begin
        bvalid_reg <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      capture_en_reg <= 1'b1;
      irq_en_reg     <= 1'b0;
      mask_reg       <= '0;
    end else if (do_write) begin
      if (aw_idx_reg == IDX_CONTROL) begin
        capture_en_reg <= wdata_reg[0];
        irq_en_reg     <= wdata_reg[1];
      end
      if (aw_idx_reg == IDX_MASK)
        mask_reg <= wdata_reg[ERR_WIDTH-1:0];
    end
  end

  // A new error pulse wins over a same-cycle write-1-to-clear of the same bit
  always_ff @(posedge clk) begin
    if (!resetn) begin
      error_reg      <= '0;
      run_status_reg <= 1'b1;
      irq_reg        <= 1'b0;
      first_err_reg  <= '0;
      first_ts_reg   <= '0;
    end else begin
      error_reg      <= (error_reg & ~w1c) | (capture_en_reg ? error_in : '0);
      run_status_reg <= armed;
      irq_reg        <= irq_en_reg & ~armed;
      if (take_snapshot) begin
        first_err_reg <= error_masked_in;
        first_ts_reg  <= cycle_cnt_reg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < DATA_WORDS; i++)
        err_data_reg[i] <= '0;
    end else if (take_snapshot) begin
      for (int i = 0; i < DATA_WORDS; i++)
        err_data_reg[i] <= snap_word[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cycle_cnt_reg  <= '0;
      pkts_reg       <= '0;
      err_events_reg <= '0;
    end else begin
      cycle_cnt_reg <= cycle_cnt_reg + 64'd1;
      if (clr_counters) begin
        pkts_reg       <= '0;
        err_events_reg <= '0;
      end else begin
        if (pkt_strobe)
          pkts_reg <= pkts_reg + 64'd1;
        if (error_masked_in != '0)
          err_events_reg <= err_events_reg + 64'd1;
      end
    end
  end

  // L halves return the value frozen by the preceding H read, if any
  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (rd_idx)
      IDX_RUN_STATUS: rd_data = {30'd0, eth_active, run_status_reg};
      IDX_CONTROL:    rd_data = {30'd0, irq_en_reg, capture_en_reg};
      IDX_ERROR:      rd_data = zext_err(error_reg);
      IDX_MASK:       rd_data = zext_err(mask_reg);
      IDX_FIRST_ERR:  rd_data = zext_err(first_err_reg);
      IDX_PKTS_H:     rd_data = pkts_reg[63:32];
      IDX_PKTS_L:     rd_data = pkts_shadow_valid_reg ? pkts_shadow_reg : pkts_reg[31:0];
      IDX_EVENTS_H:   rd_data = err_events_reg[63:32];
      IDX_EVENTS_L:   rd_data = events_shadow_valid_reg ? events_shadow_reg : err_events_reg[31:0];
      IDX_TS_H:       rd_data = first_ts_reg[63:32];
      IDX_TS_L:       rd_data = ts_shadow_valid_reg ? ts_shadow_reg : first_ts_reg[31:0];
      default: begin
        if (rd_idx >= IDX_DATA_BASE && int'(rd_idx) < 16 + DATA_WORDS)
          rd_data = err_data_reg[rd_off];
        else
          rd_resp = RESP_DECERR;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rvalid_reg              <= 1'b0;
      rdata_reg               <= '0;
      rresp_reg               <= RESP_OKAY;
      pkts_shadow_reg         <= '0;
      events_shadow_reg       <= '0;
      ts_shadow_reg           <= '0;
      pkts_shadow_valid_reg   <= 1'b0;
      events_shadow_valid_reg <= 1'b0;
      ts_shadow_valid_reg     <= 1'b0;
    end else if (ar_hs) begin
      rvalid_reg <= 1'b1;
      rdata_reg  <= rd_data;
      rresp_reg  <= rd_resp;
      case (rd_idx)
        IDX_PKTS_H: begin
          pkts_shadow_reg       <= pkts_reg[31:0];
          pkts_shadow_valid_reg <= 1'b1;
        end
        IDX_PKTS_L:   pkts_shadow_valid_reg <= 1'b0;
        IDX_EVENTS_H: begin
          events_shadow_reg       <= err_events_reg[31:0];
          events_shadow_valid_reg <= 1'b1;
        end
        IDX_EVENTS_L: events_shadow_valid_reg <= 1'b0;
        IDX_TS_H: begin
          ts_shadow_reg       <= first_ts_reg[31:0];
          ts_shadow_valid_reg <= 1'b1;
        end
        IDX_TS_L:     ts_shadow_valid_reg <= 1'b0;
        default: ;
      endcase
    end else if (rvalid_reg && S_AXI_RREADY) begin
      rvalid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_error_capture.sv
// Directed bench for axi_error_capture: register map, sticky/W1C, snapshot, mask,
// coherent counter reads, split AXI writes, clear-counters and reset abandonment.
module tb_axi_error_capture;

  logic          clk = 1'b0;
  logic          resetn;
  logic          eth_active;
  logic [31:0]   error_in;
  logic [511:0]  error_data;
  logic          pkt_strobe;
  logic          irq;
  logic          run_status;
  logic [31:0]   S_AXI_AWADDR;
  logic [2:0]    S_AXI_AWPROT;
  logic          S_AXI_AWVALID;
  logic          S_AXI_AWREADY;
  logic [31:0]   S_AXI_WDATA;
  logic [3:0]    S_AXI_WSTRB;
  logic          S_AXI_WVALID;
  logic          S_AXI_WREADY;
  logic [1:0]    S_AXI_BRESP;
  logic          S_AXI_BVALID;
  logic          S_AXI_BREADY;
  logic [31:0]   S_AXI_ARADDR;
  logic [2:0]    S_AXI_ARPROT;
  logic          S_AXI_ARVALID;
  logic          S_AXI_ARREADY;
  logic [31:0]   S_AXI_RDATA;
  logic [1:0]    S_AXI_RRESP;
  logic          S_AXI_RVALID;
  logic          S_AXI_RREADY;

  int            n_vec = 0;
  int            n_miss = 0;
  longint        tb_cyc = 0;
  longint        err_ts;

  axi_error_capture #(.ERR_WIDTH(32), .DATA_WORDS(16), .ADDR_MASK(8'hFF)) dut (
    .clk(clk), .resetn(resetn), .eth_active(eth_active),
    .error_in(error_in), .error_data(error_data), .pkt_strobe(pkt_strobe),
    .irq(irq), .run_status(run_status),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 clk = ~clk;

  // Free-running cycle count matching the timestamp source
  always @(posedge clk) begin
    if (!resetn) tb_cyc <= 0;
    else         tb_cyc <= tb_cyc + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic axi_read(input logic [5:0] idx, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge clk);
    S_AXI_ARADDR  = {24'd0, idx, 2'b00};
    S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    @(negedge clk);
    S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!S_AXI_RVALID && n < 50) begin @(negedge clk); n++; end
    if (S_AXI_RVALID) begin
      data = S_AXI_RDATA;
      resp = S_AXI_RRESP;
    end else begin
      data = 'x;
      resp = 'x;
    end
    S_AXI_RREADY = 1'b1;
    @(negedge clk);
    S_AXI_RREADY = 1'b0;
  endtask

  task automatic rd_check(input string tag, input logic [5:0] idx, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
    logic [31:0] d;
    logic [1:0]  r;
    axi_read(idx, d, r);
    check({tag, "_data"}, 64'(d), 64'(exp_data));
    check({tag, "_resp"}, 64'(r), 64'(exp_resp));
  endtask

  // W is presented first; AW follows aw_delay cycles later. BREADY held low bready_delay cycles.
  task automatic axi_write(input string tag, input logic [5:0] idx, input logic [31:0] data,
                           input int aw_delay, input int bready_delay, input bit clr_side,
                           input logic [1:0] exp_resp);
    int  cyc;
    int  n;
    bit  aw_done;
    bit  w_done;
    bit  hs_aw;
    bit  hs_w;
    @(negedge clk);
    S_AXI_WDATA  = data;
    S_AXI_WVALID = 1'b1;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 50) begin
      if (cyc >= aw_delay && !aw_done) begin
        S_AXI_AWADDR  = {24'd0, idx, 2'b00};
        S_AXI_AWVALID = 1'b1;
      end
      hs_aw = S_AXI_AWVALID && S_AXI_AWREADY;
      hs_w  = S_AXI_WVALID && S_AXI_WREADY;
      @(negedge clk);
      cyc++;
      if (hs_aw) begin aw_done = 1'b1; S_AXI_AWVALID = 1'b0; end
      if (hs_w)  begin w_done  = 1'b1; S_AXI_WVALID  = 1'b0; end
      if (w_done && !aw_done && cyc < aw_delay) check({tag, "_wready_low"}, 64'(S_AXI_WREADY), 64'd0);
    end
    n = 0;
    while (!S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    if (clr_side) begin
      error_in   = '0;
      pkt_strobe = 1'b0;
    end
    for (int i = 0; i < bready_delay; i++) begin
      check({tag, "_bvalid_held"}, 64'(S_AXI_BVALID), 64'd1);
      @(negedge clk);
    end
    check({tag, "_bvalid"}, 64'(S_AXI_BVALID), 64'd1);
    check({tag, "_bresp"}, 64'(S_AXI_BRESP), 64'(exp_resp));
    S_AXI_BREADY = 1'b1;
    @(negedge clk);
    S_AXI_BREADY = 1'b0;
    check({tag, "_bvalid_drop"}, 64'(S_AXI_BVALID), 64'd0);
  endtask

  task automatic pulse_err(input logic [31:0] bits, input logic [31:0] top_word);
    @(negedge clk);
    error_in = bits;
    error_data[511:480] = top_word;
    @(negedge clk);
    error_in = '0;
  endtask

  initial begin
    resetn = 1'b0; eth_active = 1'b0; error_in = '0; error_data = '0; pkt_strobe = 1'b0;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = 4'hF; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    check("rst_irq", 64'(irq), 64'd0);
    check("rst_run_status", 64'(run_status), 64'd1);
    check("rst_arready", 64'(S_AXI_ARREADY), 64'd0);
    check("rst_awready", 64'(S_AXI_AWREADY), 64'd0);
    check("rst_bvalid", 64'(S_AXI_BVALID), 64'd0);
    check("rst_rvalid", 64'(S_AXI_RVALID), 64'd0);
    resetn = 1'b1;

    rd_check("run_status_reg", 6'd0, 32'h1, 2'd0);
    rd_check("control_reg", 6'd1, 32'h1, 2'd0);
    rd_check("error_reg", 6'd2, 32'h0, 2'd0);
    rd_check("unmapped12", 6'd12, 32'h0, 2'd3);
    eth_active = 1'b1;
    rd_check("eth_active", 6'd0, 32'h3, 2'd0);
    eth_active = 1'b0;

    // First error at cycle 100, second error must not disturb the snapshot
    while (tb_cyc < 100) @(negedge clk);
    err_ts = tb_cyc;
    error_in = 32'h4;
    error_data[511:480] = 32'hDEADBEEF;
    error_data[31:0]    = 32'h12345678;
    @(negedge clk);
    error_in = 32'h10;
    error_data = '0;
    error_data[511:480] = 32'h11111111;
    @(negedge clk);
    error_in = '0;
    @(negedge clk);
    check("ts_cycle", 64'(err_ts), 64'd100);
    check("err_run_status", 64'(run_status), 64'd0);
    check("err_irq_disabled", 64'(irq), 64'd0);
    rd_check("error_sticky", 6'd2, 32'h14, 2'd0);
    rd_check("first_err", 6'd4, 32'h4, 2'd0);
    rd_check("err_data16", 6'd16, 32'hDEADBEEF, 2'd0);
    rd_check("err_data31", 6'd31, 32'h12345678, 2'd0);
    rd_check("first_ts_h", 6'd9, 32'h0, 2'd0);
    rd_check("first_ts_l", 6'd10, 32'd100, 2'd0);
    rd_check("events_h", 6'd7, 32'h0, 2'd0);
    rd_check("events_l", 6'd8, 32'd2, 2'd0);

    // Interrupt enable, then W-before-AW clear with BREADY stalled
    axi_write("wr_irq_en", 6'd1, 32'h3, 0, 0, 1'b0, 2'd0);
    check("irq_on", 64'(irq), 64'd1);
    axi_write("w1c_split", 6'd2, 32'h14, 3, 5, 1'b0, 2'd0);
    @(negedge clk);
    check("w1c_run_status", 64'(run_status), 64'd1);
    check("w1c_irq", 64'(irq), 64'd0);
    rd_check("w1c_error", 6'd2, 32'h0, 2'd0);

    // Re-armed snapshot
    pulse_err(32'h1, 32'hCAFEF00D);
    rd_check("rearm_first_err", 6'd4, 32'h1, 2'd0);
    rd_check("rearm_data16", 6'd16, 32'hCAFEF00D, 2'd0);
    axi_write("w1c_bit0", 6'd2, 32'h1, 0, 0, 1'b0, 2'd0);

    // Masked error: sticky but ignored for status, events and snapshot
    axi_write("wr_mask", 6'd3, 32'h4, 0, 0, 1'b0, 2'd0);
    rd_check("mask_reg", 6'd3, 32'h4, 2'd0);
    pulse_err(32'h4, 32'hBAD0BAD0);
    @(negedge clk);
    check("mask_run_status", 64'(run_status), 64'd1);
    check("mask_irq", 64'(irq), 64'd0);
    rd_check("mask_error", 6'd2, 32'h4, 2'd0);
    rd_check("mask_events_h", 6'd7, 32'h0, 2'd0);
    rd_check("mask_events_l", 6'd8, 32'd3, 2'd0);
    rd_check("mask_first_err", 6'd4, 32'h1, 2'd0);
    rd_check("mask_data16", 6'd16, 32'hCAFEF00D, 2'd0);

    // Coherent H/L read with a strobe in between
    @(negedge clk); pkt_strobe = 1'b1;
    repeat (5) @(negedge clk);
    pkt_strobe = 1'b0;
    rd_check("pkts_h", 6'd5, 32'h0, 2'd0);
    @(negedge clk); pkt_strobe = 1'b1;
    @(negedge clk); pkt_strobe = 1'b0;
    rd_check("pkts_l_shadow", 6'd6, 32'd5, 2'd0);
    rd_check("pkts_h2", 6'd5, 32'h0, 2'd0);
    rd_check("pkts_l2", 6'd6, 32'd6, 2'd0);
    @(negedge clk); pkt_strobe = 1'b1;
    @(negedge clk); pkt_strobe = 1'b0;
    rd_check("pkts_l_live", 6'd6, 32'd7, 2'd0);

    // Set wins over same-cycle W1C on bit 0; bit 2 clears
    error_in = 32'h1;
    axi_write("w1c_vs_set", 6'd2, 32'h5, 0, 0, 1'b1, 2'd0);
    rd_check("set_wins", 6'd2, 32'h1, 2'd0);
    check("set_run_status", 64'(run_status), 64'd0);
    check("set_irq", 64'(irq), 64'd1);

    // clr_counters overrides a simultaneous strobe
    pkt_strobe = 1'b1;
    axi_write("clr_counters", 6'd1, 32'h7, 0, 0, 1'b1, 2'd0);
    rd_check("clr_pkts_h", 6'd5, 32'h0, 2'd0);
    rd_check("clr_pkts_l", 6'd6, 32'h0, 2'd0);
    rd_check("clr_events_l", 6'd8, 32'h0, 2'd0);
    rd_check("clr_selfclear", 6'd1, 32'h3, 2'd0);

    // capture_en off blocks new errors
    axi_write("cap_off", 6'd1, 32'h2, 0, 0, 1'b0, 2'd0);
    pulse_err(32'h8, 32'h0);
    rd_check("cap_off_error", 6'd2, 32'h1, 2'd0);
    rd_check("cap_off_events", 6'd8, 32'h0, 2'd0);

    // Writes to read-only / unmapped registers
    axi_write("wr_ro", 6'd0, 32'hFFFF, 0, 0, 1'b0, 2'd3);
    axi_write("wr_unmapped", 6'd12, 32'hFFFF, 0, 0, 1'b0, 2'd3);
    rd_check("ro_unchanged", 6'd0, 32'h0, 2'd0);
    rd_check("ctrl_unchanged", 6'd1, 32'h2, 2'd0);

    // Reset with a write held but not yet executed
    @(negedge clk);
    S_AXI_AWADDR = {24'd0, 6'd3, 2'b00}; S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA = 32'hFF; S_AXI_WVALID = 1'b1;
    @(negedge clk);
    resetn = 1'b0;
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_bvalid", 64'(S_AXI_BVALID), 64'd0);
    check("midrst_awready", 64'(S_AXI_AWREADY), 64'd0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);
    check("postrst_bvalid", 64'(S_AXI_BVALID), 64'd0);
    check("postrst_run_status", 64'(run_status), 64'd1);
    rd_check("postrst_mask", 6'd3, 32'h0, 2'd0);
    rd_check("postrst_control", 6'd1, 32'h1, 2'd0);
    rd_check("postrst_first_err", 6'd4, 32'h0, 2'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
